// File: rtl/data_detransposer_if.sv
// Bundles the job-control, MVU RAM read-port and output word-stream signals
// of the data detransposer.
// master: the detransposer side; slave: the environment (job issuer, RAM, consumer).
interface data_detransposer_if #(
  parameter int XLEN         = 32,
  parameter int MVU_ADDR_LEN = 32,
  parameter int MVU_DATA_LEN = 64
);
  // Job control
  logic                    start;
  logic [31:0]             prec;
  logic [MVU_ADDR_LEN-1:0] baddr;
  logic                    busy;
  logic                    done;
  // MVU result RAM read port
  logic                    mvu_rd_en;
  logic [MVU_ADDR_LEN-1:0] mvu_rd_addr;
  logic [MVU_DATA_LEN-1:0] mvu_rd_word;
  // Rebuilt word stream
  logic                    oword_valid;
  logic                    oword_ready;
  logic [XLEN-1:0]         oword;
  logic                    oword_last;

  modport master (
    input  start, prec, baddr, mvu_rd_word, oword_ready,
    output busy, done, mvu_rd_en, mvu_rd_addr, oword_valid, oword, oword_last
  );

  modport slave (
    output start, prec, baddr, mvu_rd_word, oword_ready,
    input  busy, done, mvu_rd_en, mvu_rd_addr, oword_valid, oword, oword_last
  );
endinterface

// File: rtl/data_detransposer.sv
// Rebuilds NUM_WORDS bit-parallel words from `prec` bit-plane words read out of
// the MVU result RAM and streams them out over valid/ready.
// Latency: first word valid P+RD_LATENCY+1 edges after start; then one word per cycle.
// Backpressure: oword/oword_valid/oword_last hold while oword_ready is low.
// Ports: clk, rst_n (sync, active-low); bus = job control (start/prec/baddr/busy/done),
//        RAM read port (mvu_rd_en/addr/word), output stream (oword_valid/ready/oword/last).
module data_detransposer #(
  parameter int NUM_WORDS     = 64,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 32,
  parameter int MVU_DATA_LEN  = 64,
  parameter int MAX_DATA_PREC = 8,
  parameter int RD_LATENCY    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  data_detransposer_if.master bus
);

  // Widths: plane count (0..MAX inclusive), plane index, word index.
  localparam int PW = $clog2(MAX_DATA_PREC + 1);
  localparam int IW = (MAX_DATA_PREC > 1) ? $clog2(MAX_DATA_PREC) : 1;
  localparam int JW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [PW-1:0]           P_ONE      = PW'(1);
  localparam logic [PW-1:0]           P_MAX      = PW'(MAX_DATA_PREC);
  localparam logic [31:0]             PREC_MAX32 = 32'(MAX_DATA_PREC);
  localparam logic [IW-1:0]           I_ONE      = IW'(1);
  localparam logic [JW-1:0]           J_ONE      = JW'(1);
  localparam logic [JW-1:0]           J_LAST     = JW'(NUM_WORDS - 1);
  localparam logic [MVU_ADDR_LEN-1:0] A_ONE      = MVU_ADDR_LEN'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUTPUT
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                                state_q,    state_d;
  logic [PW-1:0]                         p_q,        p_d;        // clamped precision
  logic [IW-1:0]                         req_idx_q,  req_idx_d;  // plane being requested
  logic                                  rd_en_q,    rd_en_d;
  logic [MVU_ADDR_LEN-1:0]               rd_addr_q,  rd_addr_d;
  // Read-tag delay line: stage RD_LATENCY-1 lines up with valid RAM data.
  logic [RD_LATENCY-1:0]                 tag_vld_q,  tag_vld_d;
  logic [RD_LATENCY-1:0][IW-1:0]         tag_idx_q,  tag_idx_d;
  logic                                  cap_last_q, cap_last_d; // plane P-1 is in the buffer
  logic [MAX_DATA_PREC-1:0][NUM_WORDS-1:0] plane_q,  plane_d;
  logic [JW-1:0]                         j_q,        j_d;        // index of presented word
  logic [XLEN-1:0]                       oword_q,    oword_d;
  logic                                  ovalid_q,   ovalid_d;
  logic                                  olast_q,    olast_d;
  logic                                  busy_q,     busy_d;
  logic                                  done_q,     done_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   prec_clamped;
  logic            cap_vld;
  logic [IW-1:0]   cap_idx;
  logic [JW-1:0]   sel_j;
  logic [XLEN-1:0] word_sel;

  always_comb begin
    prec_clamped = bus.prec[PW-1:0];
    if (bus.prec > PREC_MAX32) begin
      prec_clamped = P_MAX;
    end
  end

  assign cap_vld = tag_vld_q[RD_LATENCY-1];
  assign cap_idx = tag_idx_q[RD_LATENCY-1];

  // WAIT loads word 0; OUTPUT preloads the word after the one being handed over.
  assign sel_j = (state_q == S_OUTPUT) ? (j_q + J_ONE) : '0;

  // Bit i of a word comes from plane i. Planes at or above P are masked so a
  // previous, higher-precision job cannot leak stale bits into this one.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < MAX_DATA_PREC; i++) begin
      if (PW'(i) < p_q) begin
        word_sel[i] = plane_q[i][sel_j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    req_idx_d  = req_idx_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    tag_vld_d  = tag_vld_q;
    tag_idx_d  = tag_idx_q;
    cap_last_d = cap_last_q;
    plane_d    = plane_q;
    j_d        = j_q;
    oword_d    = oword_q;
    ovalid_d   = ovalid_q;
    olast_d    = olast_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Each cycle the request currently on the port enters the delay line.
    tag_vld_d[0] = rd_en_q;
    tag_idx_d[0] = req_idx_q;
    for (int s = 1; s < RD_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    if (cap_vld) begin
      plane_d[cap_idx] = bus.mvu_rd_word[NUM_WORDS-1:0];
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.prec != '0)) begin
          p_d        = prec_clamped;
          req_idx_d  = '0;
          rd_en_d    = 1'b1;
          rd_addr_d  = bus.baddr;
          cap_last_d = 1'b0;
          j_d        = '0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (PW'(req_idx_q) == (p_q - P_ONE)) begin
          rd_en_d = 1'b0;
          state_d = S_WAIT;
        end else begin
          req_idx_d = req_idx_q + I_ONE;
          rd_addr_d = rd_addr_q + A_ONE;
        end
      end

      S_WAIT: begin
        // The last plane always lands after FETCH has ended, so the flag is
        // only ever raised here; word 0 is built from the buffer a cycle later.
        if (cap_vld && (PW'(cap_idx) == (p_q - P_ONE))) begin
          cap_last_d = 1'b1;
        end
        if (cap_last_q) begin
          oword_d    = word_sel;
          ovalid_d   = 1'b1;
          olast_d    = (J_LAST == '0);
          j_d        = '0;
          cap_last_d = 1'b0;
          state_d    = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        if (bus.oword_ready) begin
          if (j_q == J_LAST) begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            j_d     = j_q + J_ONE;
            oword_d = word_sel;
            olast_d = ((j_q + J_ONE) == J_LAST);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      req_idx_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
      cap_last_q <= 1'b0;
      plane_q    <= '0;
      j_q        <= '0;
      oword_q    <= '0;
      ovalid_q   <= 1'b0;
      olast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      req_idx_q  <= req_idx_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
      cap_last_q <= cap_last_d;
      plane_q    <= plane_d;
      j_q        <= j_d;
      oword_q    <= oword_d;
      ovalid_q   <= ovalid_d;
      olast_q    <= olast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mvu_rd_en   = rd_en_q;
  assign bus.mvu_rd_addr = rd_addr_q;
  assign bus.oword_valid = ovalid_q;
  assign bus.oword       = oword_q;
  assign bus.oword_last  = olast_q;

  // RAM data bits above one plane carry nothing for this block.
  if (MVU_DATA_LEN > NUM_WORDS) begin : g_rd_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^bus.mvu_rd_word[MVU_DATA_LEN-1:NUM_WORDS];
  end

endmodule

// File: tb/tb_data_detransposer.sv
module tb_data_detransposer;

  localparam int NW  = 64;
  localparam int XL  = 32;
  localparam int AL  = 32;
  localparam int DL  = 64;
  localparam int MXP = 8;
  localparam int RL  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_detransposer_if #(.XLEN(XL), .MVU_ADDR_LEN(AL), .MVU_DATA_LEN(DL)) dif ();

  data_detransposer #(
    .NUM_WORDS(NW), .XLEN(XL), .MVU_ADDR_LEN(AL), .MVU_DATA_LEN(DL),
    .MAX_DATA_PREC(MXP), .RD_LATENCY(RL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  logic [XL:0] sb[$];        // {last, word}
  logic [AL-1:0] addr_q[$];  // expected read addresses

  // RAM: one-cycle registered read; garbage when not reading.
  logic [DL-1:0] ram [0:511];
  always @(posedge clk) begin
    dif.mvu_rd_word <= dif.mvu_rd_en ? ram[dif.mvu_rd_addr[8:0]] : 64'hA5A5_A5A5_A5A5_A5A5;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dif.oword_ready = 1'b1;
      1:       dif.oword_ready = 1'($urandom_range(0, 1));
      default: dif.oword_ready = 1'b0;
    endcase
  end

  // Image 0: word j = j; image 1: word j = (37*j + 11) mod 256.
  function automatic logic [7:0] img(input int sel, input int j);
    if (sel == 0) return 8'(j);
    return 8'(j * 37 + 11);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic          prev_stall = 1'b0;
  logic          prev_done  = 1'b0;
  logic [XL+1:0] prev_word  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 64'({dif.oword_valid, dif.oword_last, dif.oword}), 64'(prev_word));
      if (dif.mvu_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rd_unexpected: read at %0h, expected no read", dif.mvu_rd_addr);
        end else begin
          chk("rd_addr", 64'(dif.mvu_rd_addr), 64'(addr_q.pop_front()));
        end
      end
      if (dif.done) begin
        done_cnt++;
        chk("done_1cyc", 64'(prev_done), 64'd0);
      end
      if (dif.oword_valid && dif.oword_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL oword_extra: got %0h, expected no word", dif.oword);
        end else begin
          chk("oword", 64'({dif.oword_last, dif.oword}), 64'(sb.pop_front()));
        end
      end
      prev_stall = dif.oword_valid && !dif.oword_ready;
      prev_word  = {dif.oword_valid, dif.oword_last, dif.oword};
      prev_done  = dif.done;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle done is high.
  task automatic run_job(input logic [31:0] prec, input logic [AL-1:0] baddr,
                         input int sel, input int exp_lat, input bit mid_start);
    int p;
    int n;
    int rd0;
    logic [XL-1:0] w;
    p = (prec > 32'(MXP)) ? MXP : int'(prec);
    for (int k = 0; k < p; k++) addr_q.push_back(baddr + AL'(k));
    for (int j = 0; j < NW; j++) begin
      w = XL'(img(sel, j)) & ((XL'(1) << p) - XL'(1));
      sb.push_back({(j == NW - 1), w});
    end
    rd0 = rd_cnt;
    dif.start = 1'b1; dif.prec = prec; dif.baddr = baddr;
    @(posedge clk); #1;
    dif.start = 1'b0;
    n = 0;
    while (!dif.oword_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("first_valid_lat", 64'(n), 64'(exp_lat));
    if (mid_start) begin
      repeat (5) @(posedge clk);
      #1;
      dif.start = 1'b1; dif.prec = 32'd3; dif.baddr = 32'h180;
      @(posedge clk); #1;
      dif.start = 1'b0;
    end
    n = 0;
    while (!dif.done && n < 2000) begin @(posedge clk); #1; n++; end
    chk("done_seen", 64'(dif.done), 64'd1);
    chk("rd_count", 64'(rd_cnt - rd0), 64'(p));
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc;
    int n;
    for (int a = 0; a < 512; a++) ram[a] = '0;
    for (int a = 32'h108; a < 32'h10C; a++) ram[a] = '1;  // trap for over-reads
    for (int k = 0; k < MXP; k++) begin
      for (int j = 0; j < NW; j++) begin
        ram[32'h100 + k][j] = img(0, j) >> k;
        ram[32'h180 + k][j] = img(1, j) >> k;
      end
    end
    dif.start = 1'b0; dif.prec = '0; dif.baddr = '0; dif.oword_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(dif.busy),        64'd0);
    chk("rst_done",  64'(dif.done),        64'd0);
    chk("rst_rd_en", 64'(dif.mvu_rd_en),   64'd0);
    chk("rst_addr",  64'(dif.mvu_rd_addr), 64'd0);
    chk("rst_valid", 64'(dif.oword_valid), 64'd0);
    chk("rst_last",  64'(dif.oword_last),  64'd0);
    chk("rst_oword", 64'(dif.oword),       64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(32'd8,  32'h100, 0, 10, 1'b0);
    run_job(32'd4,  32'h100, 0, 6,  1'b0);   // back-to-back in the done cycle
    run_job(32'd12, 32'h100, 0, 10, 1'b0);   // clamps to 8 planes

    // prec = 0 must be ignored
    dif.start = 1'b1; dif.prec = 32'd0; dif.baddr = 32'h100;
    @(posedge clk); #1;
    dif.start = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      acc = acc | int'(dif.busy) | int'(dif.mvu_rd_en) | int'(dif.oword_valid);
      @(posedge clk); #1;
    end
    chk("prec0_idle", 64'(acc), 64'd0);

    ready_mode = 1;
    run_job(32'd8, 32'h100, 0, 10, 1'b1);   // backpressure + ignored start
    ready_mode = 0;
    @(posedge clk); #1;

    run_job(32'd8, 32'h100, 0, 10, 1'b0);
    run_job(32'd2, 32'h180, 1, 4,  1'b0);   // stale upper planes must be masked

    // Reset in the middle of OUTPUT
    ready_mode = 2;
    for (int k = 0; k < 8; k++) addr_q.push_back(32'h100 + k);
    dif.start = 1'b1; dif.prec = 32'd8; dif.baddr = 32'h100;
    @(posedge clk); #1;
    dif.start = 1'b0;
    n = 0;
    while (!dif.oword_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("abort_job_valid", 64'(dif.oword_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy",  64'(dif.busy),        64'd0);
    chk("abort_done",  64'(dif.done),        64'd0);
    chk("abort_rd_en", 64'(dif.mvu_rd_en),   64'd0);
    chk("abort_addr",  64'(dif.mvu_rd_addr), 64'd0);
    chk("abort_valid", 64'(dif.oword_valid), 64'd0);
    chk("abort_last",  64'(dif.oword_last),  64'd0);
    chk("abort_oword", 64'(dif.oword),       64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_reads", 64'(addr_q.size()), 64'd0);
    sb.delete();
    ready_mode = 0;
    @(posedge clk); #1;
    run_job(32'd8, 32'h180, 1, 10, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("done_total", 64'(done_cnt), 64'd7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
